spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, DW-bit frames, MSB first, oversampled on clock_in.
//
// All SPI pins are synchronized into the clock_in domain, so sclk must run at
// clock_in/8 or slower. Frames may run back to back under one ssn low period.
//
// Ports
//   clock_in  : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   sclk      : SPI clock from master (async)
//   ssn       : active-low slave select (async)
//   mosi      : serial data from master (async)
//   miso      : serial data to master, 0 while idle
//   miso_oeb  : active-low pad enable for miso (synchronized ssn)
//   tx_data   : byte for the next outgoing frame
//   tx_load   : one-cycle strobe, captures tx_data into the holding register
//   tx_empty  : holding register has been consumed
//   rx_data   : oldest received byte
//   rx_valid  : rx_data holds an unread byte
//   rx_ack    : one-cycle pop of rx_data
//   overrun   : sticky, a completed byte was dropped; cleared by rx_ack
//   frame_err : one-cycle pulse when ssn deasserts mid-frame
//
// Configuration
//   SPI_SLAVE_RXFIFO_EN : when defined, RX storage is a 4-entry FIFO;
//                         otherwise it is a single register.

module spi_slave #(
  parameter int unsigned DW = 8
) (
  input  logic          clock_in,
  input  logic          rst,
  input  logic          sclk,
  input  logic          ssn,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oeb,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_load,
  output logic          tx_empty,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ack,
  output logic          overrun,
  output logic          frame_err
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Synchronizers plus one history flop for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic ssn_s1_q, ssn_s2_q, ssn_h_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [1:0] warm_q;
  logic armed_q;

  state_e        state_q;
  logic [CntW-1:0] cnt_q;
  logic [DW-1:0] tx_sh_q;
  logic [DW-1:0] rx_sh_q;
  logic [DW-1:0] hold_q;
  logic          tx_empty_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic          sclk_rise, sclk_fall, ssn_fall, ssn_rise;
  logic          wrap, reload, push;
  logic [DW-1:0] push_byte;

  // ssn flops reset to the deselected level so the pad stays disabled in reset.
  // warm_q/armed_q make sure a falling edge is only accepted after ssn has been
  // seen high on the real pin, so a frame in progress across reset is ignored.
  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      ssn_s1_q  <= 1'b1;
      ssn_s2_q  <= 1'b1;
      ssn_h_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      warm_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      ssn_s1_q  <= ssn;
      ssn_s2_q  <= ssn_s1_q;
      ssn_h_q   <= ssn_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      warm_q    <= {warm_q[0], 1'b1};
      armed_q   <= armed_q | (warm_q[1] & ssn_s2_q);
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;
  assign ssn_fall  = armed_q & ssn_h_q & ~ssn_s2_q;
  assign ssn_rise  = ssn_s2_q & ~ssn_h_q;

  assign wrap      = (state_q == StActive) && !ssn_rise && sclk_rise &&
                     (cnt_q == CntW'(DW - 1));
  assign push      = wrap;
  assign push_byte = {rx_sh_q[DW-2:0], mosi_s2_q};
  assign reload    = ((state_q == StIdle) && ssn_fall) || wrap;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      tx_empty_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ssn_fall) begin
            state_q <= StActive;
            cnt_q   <= '0;
          end
        end
        StActive: begin
          if (ssn_rise) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rx_sh_q <= '0;
            if (cnt_q != '0) frame_err_q <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_sh_q <= push_byte;
              cnt_q   <= wrap ? '0 : cnt_q + CntW'(1);
            end
            // The falling edge right after a wrap belongs to the previous frame;
            // skipping it keeps the freshly reloaded MSB on miso.
            if (sclk_fall && (cnt_q != '0)) tx_sh_q <= {tx_sh_q[DW-2:0], 1'b0};
          end
        end
      endcase
      if (reload) begin
        tx_sh_q    <= tx_empty_q ? '0 : hold_q;
        tx_empty_q <= 1'b1;
      end
      // A load on the reload cycle wins for the holding register and flag.
      if (tx_load) begin
        hold_q     <= tx_data;
        tx_empty_q <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  logic [DW-1:0] fifo_mem_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    fifo_cnt_q;
  logic          pop, do_push;

  assign pop     = rx_ack && (fifo_cnt_q != 3'd0);
  assign do_push = push && ((fifo_cnt_q != 3'd4) || pop);

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem_q[wr_ptr_q] <= push_byte;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + {2'b00, do_push} - {2'b00, pop};
      if (push && !do_push) overrun_q <= 1'b1;
      else if (pop)         overrun_q <= 1'b0;
    end
  end

  assign rx_data  = fifo_mem_q[rd_ptr_q];
  assign rx_valid = (fifo_cnt_q != 3'd0);
`else
  logic [DW-1:0] rx_q;
  logic          rx_valid_q;
  logic          pop;

  assign pop = rx_ack && rx_valid_q;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (push && (!rx_valid_q || pop)) begin
        rx_q       <= push_byte;
        rx_valid_q <= 1'b1;
      end else if (pop) begin
        rx_valid_q <= 1'b0;
      end
      if (push && rx_valid_q && !pop) overrun_q <= 1'b1;
      else if (pop)                   overrun_q <= 1'b0;
    end
  end

  assign rx_data  = rx_q;
  assign rx_valid = rx_valid_q;
`endif

  assign miso      = (state_q == StActive) & tx_sh_q[DW-1];
  assign miso_oeb  = ssn_s2_q;
  assign tx_empty  = tx_empty_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with a behavioural model.
// The model tracks the holding register, the RX queue, overrun and the select
// level; a compare process checks the DUT against it whenever outputs have settled.

module tb_spi_slave;

  localparam int DW = 8;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic          clock_in = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          ssn = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oeb, tx_empty, rx_valid, overrun, frame_err;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_ack = 1'b0;

  always #5 clock_in = ~clock_in;

  spi_slave #(.DW(DW)) dut (
    .clock_in  (clock_in),
    .rst       (rst),
    .sclk      (sclk),
    .ssn       (ssn),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oeb  (miso_oeb),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_empty  (tx_empty),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad = 0;
  int settle = 0;
  int fe_cnt = 0;

  // Behavioural model state.
  logic [7:0] m_hold = 8'h00;
  bit         m_empty = 1'b1;
  logic [7:0] m_rxq[$];
  bit         m_ovr = 1'b0;
  bit         m_ssn = 1'b1;
  logic [7:0] m_cur = 8'h00;
  int         m_bits = 0;
  logic [7:0] m_rxsh = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic model_reset();
    m_hold  = 8'h00;
    m_empty = 1'b1;
    m_rxq.delete();
    m_ovr   = 1'b0;
    m_ssn   = 1'b1;
    m_cur   = 8'h00;
    m_bits  = 0;
    m_rxsh  = 8'h00;
  endtask

  task automatic reload_model();
    m_cur   = m_empty ? 8'h00 : m_hold;
    m_empty = 1'b1;
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    m_hold  = v;
    m_empty = 1'b0;
    settle  = 4;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    if (m_rxq.size() > 0) begin
      m_rxq.delete(0);
      m_ovr = 1'b0;
    end
    settle = 4;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic start_frame();
    ssn    = 1'b0;
    m_ssn  = 1'b0;
    m_bits = 0;
    reload_model();
    settle = 4;
    tick(6);
  endtask

  task automatic end_frame();
    tick(4);
    ssn    = 1'b1;
    m_ssn  = 1'b1;
    m_bits = 0;
    m_rxsh = 8'h00;
    settle = 4;
    tick(6);
  endtask

  // Mode 0 master: data changes with sclk low, sampled on the rising edge.
  task automatic send_bits(input logic [7:0] tx, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      tick(4);
      check("miso_bit", 32'(miso), 32'(m_cur[7-m_bits]));
      got  = {got[6:0], miso};
      sclk = 1'b1;
      m_rxsh = {m_rxsh[6:0], tx[7-i]};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_rxq.size() < Cap) m_rxq.push_back(m_rxsh);
        else m_ovr = 1'b1;
        reload_model();
        settle = 4;
      end
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_miso_oeb"}, 32'(miso_oeb), 32'd1);
    check({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // Continuous comparison against the model once outputs have settled.
  initial begin
    forever begin
      @(posedge clock_in);
      #2;
      if (settle > 0) begin
        settle--;
      end else begin
        check("cmp_tx_empty", 32'(tx_empty), 32'(m_empty));
        check("cmp_rx_valid", 32'(rx_valid), 32'(m_rxq.size() > 0));
        check("cmp_overrun", 32'(overrun), 32'(m_ovr));
        check("cmp_miso_oeb", 32'(miso_oeb), 32'(m_ssn));
        if (m_rxq.size() > 0) check("cmp_rx_data", 32'(rx_data), 32'(m_rxq[0]));
        if (m_ssn) check("cmp_miso_idle", 32'(miso), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock_in);
      if (frame_err === 1'b1) fe_cnt++;
    end
  end

  initial begin
    logic [7:0] got;
    int fe0;

    model_reset();
    settle = 1;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    settle = 4;
    tick(6);

    // Single frame: load A5, master sends 3C.
    load_tx(8'hA5);
    start_frame();
    send_bits(8'h3C, 8, got);
    end_frame();
    check("f1_miso_byte", 32'(got), 32'hA5);
    check("f1_rx_data", 32'(rx_data), 32'h3C);
    check("f1_rx_valid", 32'(rx_valid), 32'd1);
    check("f1_tx_empty", 32'(tx_empty), 32'd1);
    ack();

    // Back-to-back frames under one select, holding reloaded in between.
    load_tx(8'h11);
    start_frame();
    load_tx(8'h22);
    send_bits(8'h01, 8, got);
    check("b2b_miso0", 32'(got), 32'h11);
    check("b2b_rx0", 32'(rx_data), 32'h01);
    ack();
    send_bits(8'h80, 8, got);
    check("b2b_miso1", 32'(got), 32'h22);
    end_frame();
    check("b2b_rx1", 32'(rx_data), 32'h80);
    check("b2b_tx_empty", 32'(tx_empty), 32'd1);
    ack();

    // Select lost after 5 bits, then a clean frame.
    fe0 = fe_cnt;
    start_frame();
    send_bits(8'hB7, 5, got);
    end_frame();
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_rx_valid", 32'(rx_valid), 32'd0);
    fe0 = fe_cnt;
    start_frame();
    send_bits(8'hFF, 8, got);
    end_frame();
    check("ferr_next_rx", 32'(rx_data), 32'hFF);
    check("ferr_next_miso", 32'(got), 32'h00);
    check("ferr_next_no_err", 32'(fe_cnt - fe0), 32'd0);
    ack();

    // Overrun without acks.
    for (int k = 0; k <= Cap; k++) begin
      start_frame();
      send_bits(8'h10 + 8'(k), 8, got);
      end_frame();
    end
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_oldest", 32'(rx_data), 32'h10);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    ack();
    check("ovr_cleared", 32'(overrun), 32'd0);
    for (int k = 0; k < 8 && m_rxq.size() > 0; k++) ack();
    tick(1);
    check("ovr_drained", 32'(rx_valid), 32'd0);

    // Reset in the middle of a frame, select held low across release.
    load_tx(8'h77);
    start_frame();
    send_bits(8'hC3, 4, got);
    fe0 = fe_cnt;
    rst = 1'b1;
    model_reset();
    settle = 2;
    tick(1);
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    m_ssn = 1'b0;
    settle = 4;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    end_frame();
    check("midrst_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    start_frame();
    send_bits(8'h5A, 8, got);
    end_frame();
    check("midrst_rx_data", 32'(rx_data), 32'h5A);
    check("midrst_miso", 32'(got), 32'h00);
    check("midrst_rx_valid2", 32'(rx_valid), 32'd1);
    ack();
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
